// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd: multi-cycle binary-to-BCD converter (shift-and-add-3).
// Converts one input bit per clock behind a start/busy/done handshake and
// flags values that do not fit in the configured number of BCD digits.

module seq_bin_to_bcd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_in_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_out_o,
    output logic                  overflow_o
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [BIN_W-1:0]  binSr_q, binSr_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  iterCnt_q, iterCnt_d;
    logic [SW-1:0]     bcd_q, bcd_d;
    logic              ovf_q, ovf_d;

    logic [SW-1:0]     scratchAdj;
    logic [SW-1:0]     scratchShifted;
    logic [BIN_W-1:0]  binShifted;
    logic              shiftOut;
    logic              accept;
    logic              lastIter;

    // A new conversion is taken whenever the converter is not mid-conversion.
    assign accept   = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign lastIter = (state_q == SHIFT) && (iterCnt_q == LAST_ITER);

    // Add 3 to every scratch digit of 5 or more; digits never carry into each other.
    always_comb begin
        scratchAdj = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                scratchAdj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Shift {scratch, binary} left by one; the scratch MSB falls out as the overflow bit.
    assign shiftOut       = scratchAdj[SW-1];
    assign scratchShifted = {scratchAdj[SW-2:0], binSr_q[BIN_W-1]};
    assign binShifted     = binSr_q << 1;

    // State register and all datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            binSr_q   <= '0;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            iterCnt_q <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            binSr_q   <= binSr_d;
            scratch_q <= scratch_d;
            sticky_q  <= sticky_d;
            iterCnt_q <= iterCnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic: IDLE/DONE both accept start, SHIFT runs BIN_W iterations.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start_i ? SHIFT : IDLE;
            SHIFT:   state_d = lastIter ? DONE : SHIFT;
            DONE:    state_d = start_i ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, iterate in SHIFT, capture results on the last iteration.
    always_comb begin
        binSr_d   = binSr_q;
        scratch_d = scratch_q;
        sticky_d  = sticky_q;
        iterCnt_d = iterCnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        if (accept) begin
            binSr_d   = bin_in_i;
            scratch_d = '0;
            sticky_d  = 1'b0;
            iterCnt_d = '0;
        end else if (state_q == SHIFT) begin
            binSr_d   = binShifted;
            scratch_d = scratchShifted;
            sticky_d  = sticky_q | shiftOut;
            iterCnt_d = iterCnt_q + CNT_W'(1);
            if (lastIter) begin
                bcd_d = scratchShifted;
                ovf_d = sticky_q | shiftOut;
            end
        end
    end

    // Output decode: busy while iterating, done for the single cycle spent in DONE.
    always_comb begin
        busy_o     = (state_q == SHIFT);
        done_o     = (state_q == DONE);
        bcd_out_o  = bcd_q;
        overflow_o = ovf_q;
    end

`ifndef SYNTHESIS
    logic digitsValid;

    // Every scratch digit must remain a legal decimal digit.
    always_comb begin
        digitsValid = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] > 4'd9) begin
                digitsValid = 1'b0;
            end
        end
    end

    scratchDigitsLegal: assert property (@(posedge clk_i) disable iff (!rst_ni) digitsValid);
    busyDoneExclusive:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(busy_o && done_o));
`endif

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// tb_seq_bin_to_bcd: self-checking bench for seq_bin_to_bcd.
// Three instances (8b/3 digits, 8b/2 digits, 16b/5 digits) are compared every
// cycle against a decimal-arithmetic model, plus directed literal checks.

module tb_seq_bin_to_bcd;

    logic clk;
    logic rst_n;

    logic        start8, start2, start16;
    logic [7:0]  bin8, bin2;
    logic [15:0] bin16;

    logic        busy8, done8, ovf8;
    logic [11:0] bcd8;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
    logic        busy16, done16, ovf16;
    logic [19:0] bcd16;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3)) u8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .bin_in_i(bin8),
        .busy_o(busy8), .done_o(done8), .bcd_out_o(bcd8), .overflow_o(ovf8)
    );

    seq_bin_to_bcd #(.BIN_W(8), .DIGITS(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .bin_in_i(bin2),
        .busy_o(busy2), .done_o(done2), .bcd_out_o(bcd2), .overflow_o(ovf2)
    );

    seq_bin_to_bcd #(.BIN_W(16), .DIGITS(5)) u16 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .bin_in_i(bin16),
        .busy_o(busy16), .done_o(done16), .bcd_out_o(bcd16), .overflow_o(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Gather per-instance signals into arrays indexed by instance number.
    int          pW[3] = '{8, 8, 16};
    int          pD[3] = '{3, 2, 5};
    logic        aStart[3];
    logic [63:0] aBin[3];
    logic        aBusy[3];
    logic        aDone[3];
    logic [63:0] aBcd[3];
    logic        aOvf[3];

    always_comb begin
        aStart[0] = start8;  aBin[0] = 64'(bin8);
        aStart[1] = start2;  aBin[1] = 64'(bin2);
        aStart[2] = start16; aBin[2] = 64'(bin16);
        aBusy[0] = busy8;  aDone[0] = done8;  aBcd[0] = 64'(bcd8);  aOvf[0] = ovf8;
        aBusy[1] = busy2;  aDone[1] = done2;  aBcd[1] = 64'(bcd2);  aOvf[1] = ovf2;
        aBusy[2] = busy16; aDone[2] = done16; aBcd[2] = 64'(bcd16); aOvf[2] = ovf16;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Decimal digits of v, low DIGITS digits only, packed four bits per digit.
    function automatic logic [63:0] toBcd(input longint v, input int nDig);
        logic [63:0] r = '0;
        longint x = v;
        for (int k = 0; k < nDig; k++) begin
            r = r | (64'(x % 10) << (4 * k));
            x = x / 10;
        end
        return r;
    endfunction

    // Behavioural model: a conversion accepted while idle finishes BIN_W edges later.
    int          mLeft[3];
    longint      mVal[3];
    logic        mDone[3];
    logic [63:0] mBcd[3];
    logic        mOvf[3];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mLeft[i] = 0; mVal[i] = 0; mDone[i] = 1'b0; mBcd[i] = '0; mOvf[i] = 1'b0;
            end else begin
                mDone[i] = 1'b0;
                if (mLeft[i] > 0) begin
                    mLeft[i] = mLeft[i] - 1;
                    if (mLeft[i] == 0) begin
                        mDone[i] = 1'b1;
                        mBcd[i]  = toBcd(mVal[i], pD[i]);
                        mOvf[i]  = (mVal[i] > pow10(pD[i]) - 1);
                    end
                end else if (aStart[i]) begin
                    mVal[i]  = longint'(aBin[i]);
                    mLeft[i] = pW[i];
                end
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("dut%0d busy", i), 64'(aBusy[i]), 64'(mLeft[i] > 0));
            checkOutput($sformatf("dut%0d done", i), 64'(aDone[i]), 64'(mDone[i]));
            checkOutput($sformatf("dut%0d bcd", i), aBcd[i], mBcd[i]);
            checkOutput($sformatf("dut%0d ovf", i), 64'(aOvf[i]), 64'(mOvf[i]));
        end
    end

    task automatic applyStimulus(input int id, input logic st, input longint v);
        case (id)
            0: begin start8  = st; bin8  = 8'(v);  end
            1: begin start2  = st; bin2  = 8'(v);  end
            default: begin start16 = st; bin16 = 16'(v); end
        endcase
    endtask

    // Pulse start for one cycle and wait (bounded) for done.
    task automatic convert(input int id, input longint v, output logic [63:0] bcd,
                           output logic ovf, output int lat, output int busyCnt);
        logic got = 1'b0;
        @(posedge clk); #2 applyStimulus(id, 1'b1, v);
        @(posedge clk); #2 applyStimulus(id, 1'b0, v);
        lat = 0;
        busyCnt = 0;
        while (!got && lat < 64) begin
            @(negedge clk);
            if (aDone[id]) got = 1'b1;
            else begin
                lat++;
                if (aBusy[id]) busyCnt++;
            end
        end
        checkOutput($sformatf("dut%0d done seen", id), 64'(got), 64'd1);
        bcd = aBcd[id];
        ovf = aOvf[id];
    endtask

    logic [63:0] rBcd;
    logic        rOvf;
    int          rLat, rBusy;

    initial begin
        int doneCyc[3];
        int doneCnt;
        logic [63:0] seenBcd;
        logic got;
        longint seq[3] = '{64'h0F, 64'hF0, 64'hFF};
        logic [63:0] seqExp[3] = '{64'h015, 64'h240, 64'h255};

        rst_n = 1'b0;
        start8 = 0; start2 = 0; start16 = 0;
        bin8 = 0; bin2 = 0; bin16 = 0;

        checkOutput("model 255 in 2 digits", toBcd(255, 2), 64'h55);
        checkOutput("model 65535 in 5 digits", toBcd(65535, 5), 64'h65535);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy8), 64'd0);
        checkOutput("reset done", 64'(done8), 64'd0);
        checkOutput("reset bcd", 64'(bcd8), 64'd0);
        checkOutput("reset ovf", 64'(ovf8), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Zero converts in BIN_W cycles with busy high the whole time.
        convert(0, 0, rBcd, rOvf, rLat, rBusy);
        checkOutput("zero latency", 64'(rLat), 64'd8);
        checkOutput("zero busy cycles", 64'(rBusy), 64'd8);
        checkOutput("zero bcd", rBcd, 64'h000);
        checkOutput("zero ovf", 64'(rOvf), 64'd0);

        // Back-to-back conversions with start held through each done cycle.
        @(posedge clk); #2 applyStimulus(0, 1'b1, seq[0]);
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int n = 0; n < 40 && !got; n++) begin
                @(negedge clk);
                if (done8) got = 1'b1;
            end
            checkOutput($sformatf("b2b done %0d", k), 64'(got), 64'd1);
            doneCyc[k] = cyc;
            checkOutput($sformatf("b2b bcd %0d", k), 64'(bcd8), seqExp[k]);
            checkOutput($sformatf("b2b ovf %0d", k), 64'(ovf8), 64'd0);
            if (k < 2) applyStimulus(0, 1'b1, seq[k+1]);
            else       applyStimulus(0, 1'b0, 0);
        end
        checkOutput("b2b spacing 1", 64'(doneCyc[1] - doneCyc[0]), 64'd9);
        checkOutput("b2b spacing 2", 64'(doneCyc[2] - doneCyc[1]), 64'd9);

        // Start and bin_in changes during busy are ignored.
        @(posedge clk); #2 applyStimulus(0, 1'b1, 100);
        @(posedge clk); #2 applyStimulus(0, 1'b0, 55);
        repeat (3) @(posedge clk);
        #2 applyStimulus(0, 1'b1, 7);
        @(posedge clk); #2 applyStimulus(0, 1'b0, 200);
        doneCnt = 0;
        seenBcd = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done8) begin doneCnt++; seenBcd = 64'(bcd8); end
        end
        checkOutput("ignored start done count", 64'(doneCnt), 64'd1);
        checkOutput("ignored start bcd", seenBcd, 64'h100);
        checkOutput("ignored start idle", 64'(busy8), 64'd0);

        // Two-digit instance: overflow keeps the low digits, then an in-range value.
        convert(1, 255, rBcd, rOvf, rLat, rBusy);
        checkOutput("d2 255 bcd", rBcd, 64'h55);
        checkOutput("d2 255 ovf", 64'(rOvf), 64'd1);
        convert(1, 99, rBcd, rOvf, rLat, rBusy);
        checkOutput("d2 99 bcd", rBcd, 64'h99);
        checkOutput("d2 99 ovf", 64'(rOvf), 64'd0);

        // Sixteen-bit instance at full scale.
        convert(2, 65535, rBcd, rOvf, rLat, rBusy);
        checkOutput("w16 latency", 64'(rLat), 64'd16);
        checkOutput("w16 bcd", rBcd, 64'h65535);
        checkOutput("w16 ovf", 64'(rOvf), 64'd0);

        // Reset mid-conversion aborts asynchronously with no done pulse.
        convert(0, 42, rBcd, rOvf, rLat, rBusy);
        checkOutput("pre-abort bcd", rBcd, 64'h042);
        @(posedge clk); #2 applyStimulus(0, 1'b1, 200);
        @(posedge clk); #2 applyStimulus(0, 1'b0, 200);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 64'(busy8), 64'd0);
        checkOutput("abort done", 64'(done8), 64'd0);
        checkOutput("abort bcd", 64'(bcd8), 64'd0);
        checkOutput("abort ovf", 64'(ovf8), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        doneCnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8) doneCnt++;
        end
        checkOutput("abort no done", 64'(doneCnt), 64'd0);
        convert(0, 200, rBcd, rOvf, rLat, rBusy);
        checkOutput("after abort bcd", rBcd, 64'h200);

        // Random start/bin_in traffic on all instances, checked by the model each cycle.
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #2;
            for (int i = 0; i < 3; i++) begin
                applyStimulus(i, ($urandom_range(0, 3) == 0), longint'($urandom & 32'hFFFF));
            end
        end
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 0);
        repeat (24) @(posedge clk);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_bin_to_bcd.md
# seq_bin_to_bcd

Parametrised, multi-cycle binary-to-BCD converter for the score and timer displays. It uses the shift-and-add-3 (double-dabble) method with a start/busy/done handshake, converting one bit per clock. It sits between the score counter and the seven-segment digit mux. It replaces the fixed 8-bit combinational converter with a width-generic block that flags results too large for the configured digit count.

## Interface
- BIN_W, default 8: width of the binary input. Legal range is 1..32.
- DIGITS, default 3: number of BCD digits produced. Legal range is 1..10.
- clk  input  1: system clock. All state updates on the rising edge.
- rst_n  input  1: asynchronous reset, active-low.
- start  input  1: request a conversion of bin_in. Sampled on the rising edge.
- bin_in  input  BIN_W: unsigned binary value. Sampled only on the edge that accepts start.
- busy  output  1: high while a conversion is in progress.
- done  output  1: one-cycle pulse when bcd_out and overflow become valid.
- bcd_out  output  4*DIGITS: packed BCD result. Digit 0 (ones) is at bits [3:0]; digit k is at bits [4k+3:4k].
- overflow  output  1: high when the value exceeds 10^DIGITS - 1. Valid with done and held with bcd_out.

## Operation
- State machine: IDLE, SHIFT, DONE.
  - IDLE, start=1: load bin_in into the binary shift register, clear the BCD scratch register and the sticky overflow flag, clear the iteration counter, go to SHIFT.
  - IDLE, start=0: stay in IDLE.
  - SHIFT: perform one iteration per cycle and increment the counter. After iteration BIN_W, go to DONE.
  - DONE: go to SHIFT if start=1 (accepts a new conversion exactly as IDLE does), otherwise go to IDLE.
- One iteration:
  - Every scratch digit >= 5 gets +3, with the 4-bit add and no carry between digits.
  - The concatenation {scratch, binary register} then shifts left by one. The binary MSB enters scratch bit 0, and binary bit 0 becomes 0.
  - If the bit shifted out of scratch bit 4*DIGITS-1 is 1, set the sticky overflow flag.
- On the final iteration:
  - Register scratch (post-shift) into bcd_out.
  - Register overflow = sticky flag OR the bit shifted out on this iteration.
  - Pulse done.
- When overflow=1, bcd_out holds the low DIGITS digits of the true decimal value. This is defined behaviour and must not be suppressed.
- bcd_out and overflow change only on a done edge or on reset. They hold between conversions.
- start while busy=1 is ignored. There is no queueing, and bin_in changes during a conversion have no effect.
- Iteration counter width is clog2(BIN_W+1).
- Every digit in the scratch register stays in the range 0..9 at all times. Any value of 10 or more is a design error and an assertion target.

## Timing
- Reset values:
  - busy=0, done=0, overflow=0, bcd_out=0.
  - State is IDLE; the scratch register, binary register and counter are all 0.
- Reset is asynchronous on assertion and is released synchronously by the existing reset synchroniser.
- Asserting rst_n low mid-conversion aborts immediately. No done pulse is produced and outputs return to their reset values.
- Latency:
  - Start is accepted on edge E0.
  - busy is high from after E0 until after E_BIN_W.
  - done, bcd_out and overflow are updated on edge E_BIN_W, i.e. BIN_W cycles after acceptance.
  - done is high for exactly one cycle.
- Throughput:
  - Back-to-back conversions: start held high in the done cycle is accepted on the next edge, with busy going high again.
  - Minimum period is BIN_W+1 cycles per conversion.
- busy and done are never high in the same cycle.

## Test plan
- Default parameters, bin_in=0x00, start pulsed for 1 cycle -> done after 8 cycles, bcd_out=0x000, overflow=0, busy high for exactly 8 cycles.
- Default parameters, with bin_in 0x0F, 0xF0 and 0xFF converted back-to-back (start held high in each done cycle):
  - bcd_out=0x015, then 0x240, then 0x255.
  - overflow=0 each time.
  - done pulses spaced 9 cycles apart.
- Default parameters, start bin_in=100, then pulse start with bin_in=7 during busy and change bin_in mid-conversion -> single done, bcd_out=0x100, and no second conversion starts.
- DIGITS=2, bin_in=255 -> bcd_out=0x55, overflow=1. Then bin_in=99 -> bcd_out=0x99, overflow=0.
- BIN_W=16, DIGITS=5, bin_in=65535 -> done after 16 cycles, bcd_out=0x65535, overflow=0.
- Default parameters, complete a conversion of 42, start 200, assert rst_n low after 4 SHIFT cycles:
  - All outputs go to 0 asynchronously, with no done pulse.
  - After release, a fresh conversion of 200 gives bcd_out=0x200.
